// File: rtl/l0_pipe_ctrl.sv
// L0 pipeline controller: circular SRAM write pointer, pending-trigger FIFO
// and a one-at-a-time SRAM read-out feeding a valid/ready event slot.
module l0_pipe_ctrl #(
  parameter int DEPTH      = 128,
  parameter int DATA_W     = 264,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              EN,
  input  logic [AW-1:0]     LATENCY,
  input  logic [DATA_W-1:0] FE_DATA,
  input  logic              L0,
  output logic              SRAM_W,
  output logic              SRAM_R,
  output logic [AW-1:0]     SRAM_WA,
  output logic [AW-1:0]     SRAM_RA,
  output logic [DATA_W-1:0] SRAM_DIN,
  input  logic [DATA_W-1:0] SRAM_DOUT,
  output logic [DATA_W-1:0] EVT_DATA,
  output logic [ID_W-1:0]   EVT_L0ID,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic              OVF
);

  localparam int            FW        = $clog2(FIFO_DEPTH);
  localparam int            EW        = AW + ID_W;
  localparam logic [AW-1:0] MIN_LAT   = AW'(3);
  localparam logic [FW:0]   FIFO_FULL = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } state_t;

  // Latencies below the read pipeline length would read a word not yet written.
  function automatic logic [AW-1:0] sat_latency(input logic [AW-1:0] lat);
    return (lat < MIN_LAT) ? MIN_LAT : lat;
  endfunction

  // ---- write stage p0 -> p1
  logic [AW-1:0]     wptr_p0;
  logic              wr_vld_p1;
  logic [AW-1:0]     wa_p1;
  logic [DATA_W-1:0] din_p1;

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      wptr_p0   <= '0;
      wr_vld_p1 <= 1'b0;
      wa_p1     <= '0;
      din_p1    <= '0;
    end else begin
      if (EN) begin
        wptr_p0 <= wptr_p0 + 1'b1;
      end
      wr_vld_p1 <= EN;
      wa_p1     <= wptr_p0;
      din_p1    <= FE_DATA;
    end
  end

  // ---- trigger capture into pending FIFO
  logic              trig;
  logic [AW-1:0]     raddr;
  logic [ID_W-1:0]   l0id;
  logic              ovf;
  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [FW:0]       fifo_wp;
  logic [FW:0]       fifo_rp;
  logic [FW:0]       fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [EW-1:0]     head;
  logic              push;
  logic              pop;
  logic              drop;

  assign trig       = L0 && EN;
  assign raddr      = wptr_p0 - sat_latency(LATENCY);
  assign fifo_cnt   = fifo_wp - fifo_rp;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign head       = fifo_mem[fifo_rp[FW-1:0]];
  // A pop on the same edge frees the slot the new trigger needs.
  assign push       = trig && (!fifo_full || pop);
  assign drop       = trig && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[fifo_wp[FW-1:0]] <= {raddr, l0id};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      fifo_wp <= '0;
      fifo_rp <= '0;
      l0id    <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) begin
        fifo_wp <= fifo_wp + 1'b1;
      end
      if (pop) begin
        fifo_rp <= fifo_rp + 1'b1;
      end
      if (trig) begin
        l0id <= l0id + 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // ---- read FSM
  state_t state;
  state_t state_nxt;
  logic   slot_free;
  logic   cap;

  assign slot_free = !EVT_VALID || EVT_READY;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && slot_free) begin
          pop       = 1'b1;
          state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP: begin
        cap       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- read stage p1 (SRAM request) -> p2 (event slot)
  logic              rd_vld_p1;
  logic [AW-1:0]     ra_p1;
  logic [ID_W-1:0]   rd_id_p1;
  logic [DATA_W-1:0] evt_data_p2;
  logic [ID_W-1:0]   evt_l0id_p2;
  logic              evt_vld_p2;

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state       <= IDLE;
      rd_vld_p1   <= 1'b0;
      ra_p1       <= '0;
      rd_id_p1    <= '0;
      evt_data_p2 <= '0;
      evt_l0id_p2 <= '0;
      evt_vld_p2  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= pop;
      if (pop) begin
        ra_p1    <= head[EW-1:ID_W];
        rd_id_p1 <= head[ID_W-1:0];
      end
      if (cap) begin
        evt_data_p2 <= SRAM_DOUT;
        evt_l0id_p2 <= rd_id_p1;
        evt_vld_p2  <= 1'b1;
      end else if (evt_vld_p2 && EVT_READY) begin
        evt_vld_p2 <= 1'b0;
      end
    end
  end

  assign SRAM_W    = wr_vld_p1;
  assign SRAM_WA   = wa_p1;
  assign SRAM_DIN  = din_p1;
  assign SRAM_R    = rd_vld_p1;
  assign SRAM_RA   = ra_p1;
  assign EVT_DATA  = evt_data_p2;
  assign EVT_L0ID  = evt_l0id_p2;
  assign EVT_VALID = evt_vld_p2;
  assign OVF       = ovf;

endmodule

// File: doc/l0_pipe_ctrl.md
L0_PIPE_CTRL -- requirements
Module: l0_pipe_ctrl

Interface
REQ-001 Parameter: DEPTH, default 128, meaning L0 pipeline depth in words; the SRAM address width is 7 bits.
REQ-002 CLK  input  1  system clock, 40 MHz; all ports are synchronous to the rising edge.
REQ-003 RSTB  input  1  synchronous reset, active-low.
REQ-004 EN  input  1  pipeline run enable.
REQ-005 LATENCY  input  7  L0 latency in BC cycles; legal range 3..127.
REQ-006 FE_DATA  input  264  front-end hit word, new value every cycle.
REQ-007 L0  input  1  L0 accept trigger, one-cycle pulse per trigger.
REQ-008 SRAM_W, SRAM_R  output  1 each  write and read enables to the 264x128 L0 SRAM.
REQ-009 SRAM_WA, SRAM_RA  output  7 each  SRAM write and read addresses.
REQ-010 SRAM_DIN  output  264  SRAM write data.
REQ-011 SRAM_DOUT  input  264  SRAM read data.
REQ-012 EVT_DATA  output  264  event data passed to L1 buffer.
REQ-013 EVT_L0ID  output  8  L0 identifier of the event.
REQ-014 EVT_VALID  output  1  event valid; EVT_READY  input  1  downstream accept.
REQ-015 OVF  output  1  sticky flag: a trigger was dropped.

Function
REQ-016 All outputs SHALL be driven from registers.
REQ-017 Write pointer WPTR SHALL increment by 1 modulo 128 every cycle while EN=1 and SHALL hold while EN=0.
REQ-018 SRAM_WA SHALL equal WPTR.
REQ-019 SRAM_DIN SHALL equal FE_DATA registered one cycle.
REQ-020 SRAM_W SHALL equal EN registered one cycle, so that the SRAM's internal W register stores SRAM_DIN at SRAM_WA on every running cycle.
REQ-021 On a cycle with L0=1 and EN=1, the block SHALL compute RADDR = (WPTR - LATENCY) mod 128.
REQ-022 LATENCY values below 3 SHALL be treated as 3.
REQ-023 On the same L0 cycle, the block SHALL push {RADDR, L0ID} into a 4-entry pending FIFO and then increment L0ID, an 8-bit counter that wraps 255->0.
REQ-024 L0 with EN=0 SHALL be ignored: no push and no L0ID change.
REQ-025 L0 arriving while the pending FIFO holds 4 entries SHALL be dropped; OVF SHALL be set and SHALL stay set until reset; L0ID SHALL still increment.
REQ-026 The read FSM SHALL have three states: IDLE, RD, CAP.
REQ-027 IDLE -> RD when the FIFO is non-empty and the output slot is free (EVT_VALID=0, or EVT_VALID=1 with EVT_READY=1 in that cycle); the transition SHALL pop the FIFO head, load SRAM_RA with it and set SRAM_R=1.
REQ-028 RD -> CAP unconditionally; SRAM_R SHALL return to 0.
REQ-029 CAP -> IDLE; at this edge the block SHALL load EVT_DATA from SRAM_DOUT, EVT_L0ID from the popped L0ID, and set EVT_VALID=1.
REQ-030 SRAM_R SHALL be high for exactly one cycle per read.
REQ-031 At most one read SHALL be in flight at a time.
REQ-032 EVT_VALID, EVT_DATA and EVT_L0ID SHALL hold stable until EVT_VALID=1 and EVT_READY=1 on the same edge.
REQ-033 On the handshake edge EVT_VALID SHALL clear, unless CAP loads a new event on that same edge.
REQ-034 Minimum latency: with an empty FIFO and a free output slot, L0 at edge t SHALL give EVT_VALID=1 after edge t+3.
REQ-035 A push and a pop in the same cycle SHALL both take effect; a full FIFO popped in the same cycle SHALL accept the new L0 without setting OVF.
REQ-036 Reads SHALL continue while EN=0, draining pending triggers.
REQ-037 Data integrity is guaranteed only if a trigger is read out within (128 - LATENCY) cycles of its L0; this is a system-level constraint and the block SHALL NOT check it.

Reset
REQ-038 When RSTB=0 at a rising edge, the following SHALL reset to 0: WPTR, L0ID, FIFO pointers, FSM (to IDLE), SRAM_W, SRAM_R, SRAM_WA, SRAM_RA, SRAM_DIN, EVT_DATA, EVT_L0ID, EVT_VALID and OVF.
REQ-039 Reset asserted mid-read SHALL abort the read and discard all pending triggers, with no EVT_VALID afterwards.

Verification
REQ-040 Wrap test: EN=1 with FE_DATA = cycle count for 300 cycles -> SRAM_WA wraps 127->0, and every SRAM write pairs address A with the FE_DATA presented one cycle earlier.
REQ-041 Latency test: LATENCY=20, EVT_READY=1, single L0 when WPTR=50 -> SRAM_RA=30, SRAM_R high for one cycle, EVT_VALID three cycles after L0, EVT_DATA = the word written at address 30, EVT_L0ID=0.
REQ-042 Address-wrap test: LATENCY=10, L0 at WPTR=5 -> SRAM_RA=123.
REQ-043 Backpressure and overflow test: EVT_READY=0, six L0 pulses on consecutive cycles -> first event held stable, 4 queued, one dropped, OVF=1; raising EVT_READY -> events delivered with L0ID 0,1,2,3,4 in order.
REQ-044 Clamp and reset test: LATENCY=1 behaves as LATENCY=3; RSTB=0 during RD state -> all outputs return to 0 and no event is emitted.
